// File: rtl/rf_wport_arbiter_if.sv
// Register-file write-port arbiter bus: WB request, long-latency result handshake,
// RF write port and pending-destination mask.
interface rf_wport_arbiter_if;
   logic        ws_we;
   logic [4:0]  ws_waddr;
   logic [31:0] ws_wdata;
   logic        ws_block;
   logic        lu_valid;
   logic        lu_ready;
   logic [4:0]  lu_waddr;
   logic [31:0] lu_wdata;
   logic        rf_we;
   logic [4:0]  rf_waddr;
   logic [31:0] rf_wdata;
   logic [31:0] pending_mask;

   modport master (
      output ws_we, ws_waddr, ws_wdata, lu_valid, lu_waddr, lu_wdata,
      input  ws_block, lu_ready, rf_we, rf_waddr, rf_wdata, pending_mask
   );

   modport slave (
      input  ws_we, ws_waddr, ws_wdata, lu_valid, lu_waddr, lu_wdata,
      output ws_block, lu_ready, rf_we, rf_waddr, rf_wdata, pending_mask
   );
endinterface

// File: rtl/rf_wport_arbiter.sv
// Shares the RF write port between WB and a buffered long-latency result FIFO,
// with starvation protection. Define RF_ARB_BYPASS_EN for same-cycle result bypass.
module rf_wport_arbiter #(
   parameter int DEPTH        = 2,
   parameter int STARVE_LIMIT = 4
) (
   input logic               clk,
   input logic               resetn,
   rf_wport_arbiter_if.slave bus
);
   localparam int PW = $clog2(DEPTH);
   localparam int CW = $clog2(STARVE_LIMIT + 1);
   localparam logic [PW:0]   DEPTH_C = (PW + 1)'(DEPTH);
   localparam logic [CW-1:0] LIMIT_C = CW'(STARVE_LIMIT);

   logic [4:0]    waddr_mem [DEPTH];
   logic [31:0]   wdata_mem [DEPTH];
   logic [PW-1:0] rd_ptr, wr_ptr;
   logic [PW:0]   count;
   logic [CW-1:0] starve_cnt, starve_nxt;
   logic          ws_block_q;

   logic non_empty, full, wb_wr, pop, push_acc, push_store, bypass;
   logic [PW-1:0] offs;
   logic [31:0]   pend;

   always_comb begin
      non_empty = (count != '0);
      full      = (count == DEPTH_C);
      wb_wr     = bus.ws_we && (bus.ws_waddr != 5'd0);
      // A forced slot beats WB; otherwise the head only drains into an idle slot.
      pop       = resetn && non_empty && (ws_block_q || !wb_wr);
      push_acc  = resetn && bus.lu_valid && !full;
`ifdef RF_ARB_BYPASS_EN
      bypass    = push_acc && !non_empty && !wb_wr && !ws_block_q &&
                  (bus.lu_waddr != 5'd0);
`else
      bypass    = 1'b0;
`endif
      push_store = push_acc && (bus.lu_waddr != 5'd0) && !bypass;
   end

   always_comb begin
      if (!non_empty || pop)
         starve_nxt = '0;
      else if (starve_cnt == LIMIT_C)
         starve_nxt = LIMIT_C;
      else
         starve_nxt = starve_cnt + CW'(1);
   end

   always_comb begin
      bus.rf_we    = 1'b0;
      bus.rf_waddr = 5'd0;
      bus.rf_wdata = 32'd0;
      if (pop) begin
         bus.rf_we    = 1'b1;
         bus.rf_waddr = waddr_mem[rd_ptr];
         bus.rf_wdata = wdata_mem[rd_ptr];
      end else if (resetn && wb_wr) begin
         bus.rf_we    = 1'b1;
         bus.rf_waddr = bus.ws_waddr;
         bus.rf_wdata = bus.ws_wdata;
      end else if (bypass) begin
         bus.rf_we    = 1'b1;
         bus.rf_waddr = bus.lu_waddr;
         bus.rf_wdata = bus.lu_wdata;
      end
   end

   // Slot i is live when its distance from the read pointer is below the count.
   always_comb begin
      pend = 32'd0;
      offs = '0;
      for (int i = 0; i < DEPTH; i++) begin
         offs = PW'(i) - rd_ptr;
         if ({1'b0, offs} < count)
            pend[waddr_mem[i]] = 1'b1;
      end
      pend[0] = 1'b0;
      if (!resetn)
         pend = 32'd0;
   end

   assign bus.pending_mask = pend;
   assign bus.lu_ready     = resetn && !full;
   assign bus.ws_block     = ws_block_q;

   always_ff @(posedge clk) begin
      if (!resetn) begin
         rd_ptr     <= '0;
         wr_ptr     <= '0;
         count      <= '0;
         starve_cnt <= '0;
         ws_block_q <= 1'b0;
      end else begin
         if (push_store)
            wr_ptr <= wr_ptr + PW'(1);
         if (pop)
            rd_ptr <= rd_ptr + PW'(1);
         case ({push_store, pop})
            2'b10:   count <= count + (PW + 1)'(1);
            2'b01:   count <= count - (PW + 1)'(1);
            default: count <= count;
         endcase
         starve_cnt <= starve_nxt;
         ws_block_q <= (starve_nxt == LIMIT_C);
      end
   end

   always_ff @(posedge clk) begin
      if (push_store) begin
         waddr_mem[wr_ptr] <= bus.lu_waddr;
         wdata_mem[wr_ptr] <= bus.lu_wdata;
      end
   end
endmodule

// File: tb/tb_rf_wport_arbiter.sv
// Bench for rf_wport_arbiter: queue-based reference model plus directed scenarios
// and randomized traffic including mid-run resets.
module tb_rf_wport_arbiter;
   localparam int DEPTH = 2;
   localparam int LIM   = 4;

   logic clk;
   logic resetn;
   rf_wport_arbiter_if bus ();

   rf_wport_arbiter #(.DEPTH(DEPTH), .STARVE_LIMIT(LIM)) dut (
      .clk    (clk),
      .resetn (resetn),
      .bus    (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      logic [4:0]  a;
      logic [31:0] d;
   } ent_t;

   ent_t        q[$];
   int          m_cnt;
   bit          m_block;
   bit          e_pop, e_store, e_bypass;
   logic        e_we, e_ready;
   logic [4:0]  e_addr;
   logic [31:0] e_data, e_mask;
   int          n_chk, n_err;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", nm, act, exp, $time);
      end
   endtask

   // Expected outputs for the current cycle from queue state and present inputs.
   task automatic model_eval();
      bit acc, wb;
      e_ready  = resetn && (q.size() < DEPTH);
      acc      = bus.lu_valid && e_ready;
      wb       = bus.ws_we && (bus.ws_waddr != 5'd0);
      e_pop    = 0;
      e_bypass = 0;
      e_we     = 0;
      e_addr   = 5'd0;
      e_data   = 32'd0;
      if (resetn) begin
         if (m_block && q.size() > 0) e_pop = 1;
         else if (wb) begin
            e_we = 1; e_addr = bus.ws_waddr; e_data = bus.ws_wdata;
         end else if (q.size() > 0) e_pop = 1;
`ifdef RF_ARB_BYPASS_EN
         else if (acc && bus.lu_waddr != 5'd0) begin
            e_bypass = 1; e_we = 1; e_addr = bus.lu_waddr; e_data = bus.lu_wdata;
         end
`endif
      end
      if (e_pop) begin
         e_we = 1; e_addr = q[0].a; e_data = q[0].d;
      end
      e_store = acc && (bus.lu_waddr != 5'd0) && !e_bypass;
      e_mask  = 32'd0;
      if (resetn)
         foreach (q[i]) e_mask |= (32'd1 << q[i].a);
   endtask

   task automatic settle();
      #3;
      model_eval();
      chk("rf_we", {31'd0, bus.rf_we}, {31'd0, e_we});
      if (e_we) begin
         chk("rf_waddr", {27'd0, bus.rf_waddr}, {27'd0, e_addr});
         chk("rf_wdata", bus.rf_wdata, e_data);
      end
      chk("lu_ready", {31'd0, bus.lu_ready}, {31'd0, e_ready});
      chk("ws_block", {31'd0, bus.ws_block}, {31'd0, m_block});
      chk("pending_mask", bus.pending_mask, e_mask);
   endtask

   task automatic step();
      ent_t e;
      @(posedge clk);
      if (!resetn) begin
         q.delete();
         m_cnt   = 0;
         m_block = 0;
      end else begin
         if (q.size() > 0 && !e_pop) m_cnt = (m_cnt + 1 > LIM) ? LIM : m_cnt + 1;
         else m_cnt = 0;
         m_block = (m_cnt == LIM);
         if (e_pop) void'(q.pop_front());
         if (e_store) begin
            e.a = bus.lu_waddr; e.d = bus.lu_wdata;
            q.push_back(e);
         end
      end
      #1;
   endtask

   task automatic drive(input bit we, input logic [4:0] wa, input logic [31:0] wd,
                        input bit lv, input logic [4:0] la, input logic [31:0] ld);
      bus.ws_we = we; bus.ws_waddr = wa; bus.ws_wdata = wd;
      bus.lu_valid = lv; bus.lu_waddr = la; bus.lu_wdata = ld;
   endtask

   int ord[3];
   int n_ord;
   bit accepted, seen;

   initial begin
      n_chk = 0; n_err = 0; m_cnt = 0; m_block = 0;
      e_pop = 0; e_store = 0;
      resetn = 1'b0;
      drive(0, 0, 0, 0, 0, 0);
      #3;
      chk("rst_lu_ready", {31'd0, bus.lu_ready}, 32'd0);
      chk("rst_rf_we", {31'd0, bus.rf_we}, 32'd0);
      step();
      settle(); step();
      resetn = 1'b1;
      settle();
      chk("idle_block", {31'd0, bus.ws_block}, 32'd0);
      chk("idle_ready", {31'd0, bus.lu_ready}, 32'd1);
      step();

      // Single result into an idle port.
      drive(0, 0, 0, 1, 5'd5, 32'h1234);
      settle();
`ifdef RF_ARB_BYPASS_EN
      chk("t1_we", {31'd0, bus.rf_we}, 32'd1);
      chk("t1_addr", {27'd0, bus.rf_waddr}, 32'd5);
      chk("t1_data", bus.rf_wdata, 32'h1234);
      chk("t1_mask0", bus.pending_mask, 32'd0);
`else
      chk("t1_we0", {31'd0, bus.rf_we}, 32'd0);
`endif
      step();
      drive(0, 0, 0, 0, 0, 0);
      settle();
`ifdef RF_ARB_BYPASS_EN
      chk("t1_we_next", {31'd0, bus.rf_we}, 32'd0);
      chk("t1_mask1", bus.pending_mask, 32'd0);
`else
      chk("t1_we", {31'd0, bus.rf_we}, 32'd1);
      chk("t1_addr", {27'd0, bus.rf_waddr}, 32'd5);
      chk("t1_data", bus.rf_wdata, 32'h1234);
      chk("t1_mask1", bus.pending_mask, 32'h20);
`endif
      step();
      settle();
      chk("t1_mask2", bus.pending_mask, 32'd0);
      step();

      // Starvation: WB hogs the port, r7 waits four denied cycles.
      drive(1, 5'd3, 32'hA3, 1, 5'd7, 32'h77);
      settle(); step();
      bus.lu_valid = 0;
      for (int k = 1; k <= 4; k++) begin
         settle();
         chk("t2_wb_addr", {27'd0, bus.rf_waddr}, 32'd3);
         chk("t2_noblock", {31'd0, bus.ws_block}, 32'd0);
         chk("t2_mask", bus.pending_mask, 32'h80);
         step();
      end
      settle();
      chk("t2_block", {31'd0, bus.ws_block}, 32'd1);
      chk("t2_r7_addr", {27'd0, bus.rf_waddr}, 32'd7);
      chk("t2_r7_data", bus.rf_wdata, 32'h77);
      step();
      settle();
      chk("t2_unblock", {31'd0, bus.ws_block}, 32'd0);
      chk("t2_wb_again", {27'd0, bus.rf_waddr}, 32'd3);
      step();

      // Fill, hold a third result until space frees, and check ordering.
      n_ord = 0; ord = '{0, 0, 0};
      drive(1, 5'd3, 32'hA3, 1, 5'd8, 32'h88);
      settle(); chk("t3_rdy0", {31'd0, bus.lu_ready}, 32'd1); step();
      drive(1, 5'd3, 32'hA3, 1, 5'd9, 32'h99);
      settle(); chk("t3_rdy1", {31'd0, bus.lu_ready}, 32'd1); step();
      drive(1, 5'd3, 32'hA3, 1, 5'd10, 32'hAA);
      accepted = 0;
      for (int k = 0; k < 20; k++) begin
         settle();
         if (k == 0) chk("t3_full", {31'd0, bus.lu_ready}, 32'd0);
         if (bus.rf_we && bus.rf_waddr != 5'd3 && n_ord < 3) begin
            ord[n_ord] = int'(bus.rf_waddr); n_ord++;
         end
         if (bus.lu_ready) begin
            accepted = 1;
            chk("t3_held_until_pop", (n_ord >= 1) ? 32'd1 : 32'd0, 32'd1);
            step();
            break;
         end
         step();
      end
      if (!accepted) chk("t3_accept_timeout", 32'd0, 32'd1);
      drive(0, 0, 0, 0, 0, 0);
      for (int k = 0; k < 10 && n_ord < 3; k++) begin
         settle();
         if (bus.rf_we && bus.rf_waddr != 5'd3 && n_ord < 3) begin
            ord[n_ord] = int'(bus.rf_waddr); n_ord++;
         end
         step();
      end
      chk("t3_ord0", ord[0], 32'd8);
      chk("t3_ord1", ord[1], 32'd9);
      chk("t3_ord2", ord[2], 32'd10);

      // Result to r0 is accepted and dropped.
      drive(0, 0, 0, 1, 5'd0, 32'hDEAD);
      settle();
      chk("t4_ready", {31'd0, bus.lu_ready}, 32'd1);
      chk("t4_we", {31'd0, bus.rf_we}, 32'd0);
      step();
      drive(0, 0, 0, 0, 0, 0);
      settle();
      chk("t4_we_next", {31'd0, bus.rf_we}, 32'd0);
      chk("t4_mask", bus.pending_mask, 32'd0);
      step();

      // WB to r0 leaves the slot free for the FIFO head.
      drive(1, 5'd3, 32'hA3, 1, 5'd4, 32'h44);
      settle(); step();
      drive(1, 5'd0, 32'h55, 0, 0, 0);
      settle();
      chk("t5_we", {31'd0, bus.rf_we}, 32'd1);
      chk("t5_addr", {27'd0, bus.rf_waddr}, 32'd4);
      chk("t5_data", bus.rf_wdata, 32'h44);
      step();
      settle();
      chk("t5_mask", bus.pending_mask, 32'd0);
      step();

      // Reset while full and blocked.
      drive(1, 5'd3, 32'hA3, 1, 5'd11, 32'hB1);
      settle(); step();
      drive(1, 5'd3, 32'hA3, 1, 5'd12, 32'hB2);
      settle(); step();
      bus.lu_valid = 0;
      seen = 0;
      for (int k = 0; k < 10; k++) begin
         if (bus.ws_block) begin seen = 1; break; end
         settle(); step();
      end
      chk("t6_block_seen", {31'd0, seen}, 32'd1);
      resetn = 1'b0;
      settle();
      chk("t6_rst_we", {31'd0, bus.rf_we}, 32'd0);
      chk("t6_rst_ready", {31'd0, bus.lu_ready}, 32'd0);
      chk("t6_rst_mask", bus.pending_mask, 32'd0);
      step();
      resetn = 1'b1;
      drive(0, 0, 0, 0, 0, 0);
      settle();
      chk("t6_rel_ready", {31'd0, bus.lu_ready}, 32'd1);
      chk("t6_rel_block", {31'd0, bus.ws_block}, 32'd0);
      chk("t6_rel_we", {31'd0, bus.rf_we}, 32'd0);
      step();

      // Randomized traffic.
      for (int c = 0; c < 1500; c++) begin
         resetn = ($urandom_range(0, 99) != 0);
         bus.ws_we    = ($urandom_range(0, 9) < 7);
         bus.ws_waddr = ($urandom_range(0, 7) == 0) ? 5'd0 : 5'($urandom_range(1, 31));
         bus.ws_wdata = $urandom;
         bus.lu_valid = ($urandom_range(0, 1) == 1);
         bus.lu_waddr = ($urandom_range(0, 9) == 0) ? 5'd0 : 5'($urandom_range(1, 31));
         bus.lu_wdata = $urandom;
         settle();
         step();
      end

      $display("Result: errors=%0d of %0d checks", n_err, n_chk);
      $finish;
   end
endmodule
